// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - parallel output bus of the UART receiver (parity_err present with UART_RX_PARITY_EN)
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_busy;
    logic                 frame_err;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    modport master (
        output rx_data,
        output rx_valid,
        output rx_busy,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output frame_err
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input rx_busy,
`ifdef UART_RX_PARITY_EN
        input parity_err,
`endif
        input frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver; define UART_RX_PARITY_EN for the parity bit and parity_err
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        rst_n_a,
    input  logic        tick,
    input  logic        rx,
`ifdef UART_RX_PARITY_EN
    input  logic        parity_odd,
`endif
    uart_rx_if.master   rx_bus
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t               state_q;
    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bad_q;
    logic                 parity_err_q;
`endif

    logic [CNT_W-1:0]     cnt_d;
    logic [DATA_BITS-1:0] shift_d;
    logic                 bit_point;

    assign cnt_d     = cnt_q + 1'b1;
    // LSB arrives first, so each new bit enters at the MSB and walks down.
    assign shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
    assign bit_point = tick && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (cnt_q == CNT_HALF) begin
                            cnt_q     <= '0;
                            bit_cnt_q <= '0;
                            // A line that is high again at mid start bit was a glitch.
                            state_q   <= rx_s_q ? IDLE : DATA;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                DATA: begin
                    if (bit_point) begin
                        cnt_q     <= '0;
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end else if (tick) begin
                        cnt_q <= cnt_d;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_point) begin
                        cnt_q        <= '0;
                        parity_bad_q <= (^shift_q) ^ rx_s_q ^ parity_odd;
                        state_q      <= STOP;
                    end else if (tick) begin
                        cnt_q <= cnt_d;
                    end
                end
`endif
                STOP: begin
                    if (bit_point) begin
                        cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= parity_bad_q;
`endif
                        if (rx_s_q) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_IDLE;
                        end
                    end else if (tick) begin
                        cnt_q <= cnt_d;
                    end
                end
                WAIT_IDLE: begin
                    // A break holds the line low; wait for idle before rearming.
                    if (rx_s_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_bus.rx_data   = rx_data_q;
    assign rx_bus.rx_valid  = rx_valid_q;
    assign rx_bus.frame_err = frame_err_q;
    assign rx_bus.rx_busy   = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_bus.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx (parity cases run with UART_RX_PARITY_EN)
module tb_uart_rx;
    localparam int DB      = 8;
    localparam int OS      = 16;
    localparam int BIT_CLK = 64;

    logic clk     = 1'b0;
    logic rst_n_a = 1'b0;
    logic tick    = 1'b0;
    logic rx      = 1'b1;
`ifdef UART_RX_PARITY_EN
    logic parity_odd = 1'b0;
`endif

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst_n_a    (rst_n_a),
        .tick       (tick),
        .rx         (rx),
`ifdef UART_RX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .rx_bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    int cycle = 0;
    int tick_total = 0;
    always @(posedge clk) begin
        cycle = cycle + 1;
        if (tick) tick_total = tick_total + 1;
    end

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
        logic       perr;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   start_cycle = 0;
    bit   lat_armed = 0;
    bit   gap_mode  = 0;
    bit   have_prev = 0;
    int   prev_tick = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cycle);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n_a) begin
            if (bus.rx_valid && bus.frame_err) check("valid_ferr_exclusive", 1, 0);
            if (bus.rx_valid || bus.frame_err) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("kind_frame_err", int'(bus.frame_err), int'(e.is_err));
                    check("rx_data", int'(bus.rx_data), int'(e.data));
`ifdef UART_RX_PARITY_EN
                    check("parity_err", int'(bus.parity_err), int'(e.perr));
`endif
                end
                if (bus.rx_valid && lat_armed) begin
                    lat_armed = 0;
                    check("valid_latency_window",
                          int'((cycle - start_cycle) >= 600 && (cycle - start_cycle) <= 620), 1);
                end
                if (bus.rx_valid && gap_mode) begin
                    if (have_prev) check("b2b_spacing_ticks", tick_total - prev_tick, 160);
                    have_prev = 1;
                    prev_tick = tick_total;
                end
            end
        end
    end

    function automatic logic good_par(input logic [7:0] d);
`ifdef UART_RX_PARITY_EN
        return (^d) ^ parity_odd;
`else
        return ^d;
`endif
    endfunction

    task automatic hold_bit(input logic v);
        rx = v;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic pbit);
        start_cycle = cycle;
        hold_bit(1'b0);
        for (int i = 0; i < DB; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        hold_bit(pbit);
`else
        if (pbit === 1'bx) $display("note: parity bit unused");
`endif
        hold_bit(stop_bit);
    endtask

    task automatic push(input logic is_err, input logic [7:0] d, input logic perr);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        e.perr   = perr;
        q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit busy_seen;
        repeat (5) @(negedge clk);
        check("reset_rx_data", int'(bus.rx_data), 0);
        check("reset_rx_valid", int'(bus.rx_valid), 0);
        check("reset_rx_busy", int'(bus.rx_busy), 0);
        check("reset_frame_err", int'(bus.frame_err), 0);
        rst_n_a = 1'b1;
        repeat (20) @(negedge clk);

        push(1'b0, 8'hA5, 1'b0);
        lat_armed = 1;
        send_frame(8'hA5, 1'b1, good_par(8'hA5));
        drain();
        check("latency_measured", int'(lat_armed), 0);

        busy_seen = 0;
        rx = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.rx_busy) busy_seen = 1;
        end
        rx = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (bus.rx_busy) busy_seen = 1;
        end
        check("glitch_busy_seen", int'(busy_seen), 1);
        check("glitch_back_idle", int'(bus.rx_busy), 0);

        push(1'b1, 8'hA5, 1'b0);
        send_frame(8'h3C, 1'b0, good_par(8'h3C));
        rx = 1'b0;
        repeat (20 * BIT_CLK) @(negedge clk);
        drain();
        check("ferr_data_held", int'(bus.rx_data), 8'hA5);
        check("break_busy_held", int'(bus.rx_busy), 1);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        push(1'b0, 8'h81, 1'b0);
        send_frame(8'h81, 1'b1, good_par(8'h81));
        drain();

        gap_mode = 1;
        push(1'b0, 8'h00, 1'b0);
        push(1'b0, 8'hFF, 1'b0);
        send_frame(8'h00, 1'b1, good_par(8'h00));
        send_frame(8'hFF, 1'b1, good_par(8'hFF));
        drain();
        gap_mode = 0;
        check("b2b_pair_seen", int'(have_prev), 1);
        repeat (40) @(negedge clk);

        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(1'(8'h55 >> i));
        rx = 1'b1;
        repeat (BIT_CLK / 2) @(negedge clk);
        rst_n_a = 1'b0;
        @(negedge clk);
        check("midrst_rx_data", int'(bus.rx_data), 0);
        check("midrst_rx_valid", int'(bus.rx_valid), 0);
        check("midrst_rx_busy", int'(bus.rx_busy), 0);
        check("midrst_frame_err", int'(bus.frame_err), 0);
        repeat (10) @(negedge clk);
        rst_n_a = 1'b1;
        repeat (50) @(negedge clk);
        push(1'b0, 8'h66, 1'b0);
        send_frame(8'h66, 1'b1, good_par(8'h66));
        drain();

`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        repeat (20) @(negedge clk);
        push(1'b0, 8'h07, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        push(1'b0, 8'h07, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
        drain();
`endif

        repeat (50) @(negedge clk);
        check("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that consumes the oversampling tick from the baud-rate generator and recovers serial frames from the `rx` line. Frame format is 1 start bit, DATA_BITS data bits (LSB first), an optional parity bit and 1 stop bit. Each completed byte is presented on a parallel bus with a one-cycle valid strobe. Sits directly downstream of the baud generator, which is programmed for a tick rate of 16x the baud.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..8)
OVERSAMPLE, 16, ticks per bit period (even, >=8)

Ports:
clk  input  1  system clock
rst_n_a  input  1  asynchronous active-low reset
tick  input  1  oversample strobe from baud generator, 1 clk wide
rx  input  1  serial line, idle high, asynchronous to clk
rx_data  output  DATA_BITS  last correctly received word
rx_valid  output  1  1-clk pulse: rx_data updated
rx_busy  output  1  high while a frame is in progress (state != IDLE)
frame_err  output  1  1-clk pulse: stop bit sampled low

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. Clock port is `clk`, reset port is `rst_n_a`.
- Reset values: rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, state=IDLE, synchroniser flops=1.
- Synchroniser: `rx` passes through a 2-flop synchroniser (rx_s); all decisions use rx_s.
- Tick counter: a tick counter of width clog2(OVERSAMPLE) advances only on cycles with tick=1.
- Bit counter: counts received data bits.
- State IDLE:
  - rx_s==0 -> START; tick counter cleared.
  - No tick is needed to leave IDLE.
- State START:
  - On the tick where the counter reaches OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - rx_s==0 -> DATA; tick and bit counters cleared.
  - rx_s==1 -> IDLE (glitch reject); no outputs pulse.
- State DATA:
  - On every OVERSAMPLE-th tick (counter == OVERSAMPLE-1), sample rx_s into a shift register, LSB first (shift right, new bit into MSB).
  - After DATA_BITS samples -> STOP, or -> PARITY when the option is enabled.
- State STOP:
  - On counter == OVERSAMPLE-1, sample rx_s.
  - 1: rx_data <= shift register; rx_valid=1 for the next clk cycle only; -> IDLE.
  - 0: frame_err=1 for one clk; rx_data unchanged; rx_valid stays 0; -> WAIT_IDLE.
- State WAIT_IDLE: stay until rx_s==1, then -> IDLE. This prevents a held-low line (break) from retriggering frames.
- Latency: rx_valid asserts on the clk edge following the tick that samples the stop bit.
- Back-to-back frames: a new start edge is accepted in IDLE on the clk immediately after the valid pulse. Stop-bit sampling at bit-centre gives half a bit of margin.
- tick with rx_s change in the same cycle: the sample uses the registered rx_s value of that cycle.
- Reset mid-frame: immediately aborts to IDLE with the reset values above. No partial word is ever published.
- rx_data holds its value between valid pulses and is not cleared on errors.
- rx_valid and frame_err are never high in the same cycle.

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds input `parity_odd` (1 bit; 0=even, 1=odd) and output `parity_err` (1-clk pulse).
  - Adds state PARITY between DATA and STOP; the parity bit is sampled at counter == OVERSAMPLE-1.
  - Mismatch: parity_err pulses in the same cycle the stop result is reported, i.e. together with rx_valid or frame_err.
  - rx_data is still updated if the stop bit is good; the consumer decides what to do with the word.
- Undefined: no parity state, no extra ports, frame length is 1+DATA_BITS+1 bits.

Test Plan:
- Tick every 4 clk (OVERSAMPLE=16 -> 64 clk/bit); send 0xA5 (frame 0,1,0,1,0,0,1,0,1,1) -> rx_data=0xA5, exactly one rx_valid pulse ~9.5 bit times after the start edge, frame_err never set.
- Drive rx low for 3 ticks then high -> state returns to IDLE, no rx_valid, no frame_err, rx_busy high only during the glitch window.
- Send 0x3C with stop bit 0, then hold rx low for 20 bit times -> single frame_err pulse, rx_data keeps its previous value, no new frame until rx returns high, then 0x81 received correctly.
- Back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses carrying 0x00 then 0xFF, 160 ticks apart.
- Assert rst_n_a during data bit 4 of 0x55, release, send 0x66 -> all outputs 0 during reset, single rx_valid with rx_data=0x66, no output from the aborted frame.
- UART_RX_PARITY_EN, parity_odd=0: send 0x07 with parity bit 1 -> rx_valid with 0x07, parity_err=0; resend with parity bit 0 -> rx_valid and parity_err pulse in the same cycle.
